// File: rtl/fd_pipe_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fd_pkg
//  Description : Shared constants and types for the Fetch-to-Decode pipeline
//                stage: default field widths, bubble (NOP) slot values and
//                the three-state occupancy encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fd_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_CNT_W   = 16;

  localparam logic [31:0] DEF_BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_BUBBLE_PC    = 32'h0010_0000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  // EMPTY: nothing held; FULL: main slot valid; SKID: main and skid valid
  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL,
    S_SKID  = ST_SKID
  } fd_state_t;

endpackage : fd_pkg
`default_nettype wire

// File: rtl/fd_pipe_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fd_pipe_stage_if
//  Description : Bundles the Fetch-side handshake, Decode-side outputs,
//                control inputs and performance counters of fd_pipe_stage.
//  Modports    : master - the environment (drives Fetch beats, stall, flush)
//                slave  - the pipeline stage itself
//  Signals     : in_valid/in_ready/in_instr/in_pc4  Fetch handshake
//                stall/flush                        Decode control
//                out_valid/out_instr/out_pc4        Decode beat
//                stall_cnt/flush_cnt                saturating event counters
//  Revision    : 1.0  initial release
// ============================================================================
interface fd_pipe_stage_if
  import fd_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc4;
  logic               stall;
  logic               flush;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc4;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output in_valid, in_instr, in_pc4, stall, flush,
    input  in_ready, out_valid, out_instr, out_pc4, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc4, stall, flush,
    output in_ready, out_valid, out_instr, out_pc4, stall_cnt, flush_cnt
  );

endinterface : fd_pipe_stage_if
`default_nettype wire

// File: rtl/fd_pipe_stage_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that increments by one per cycle with inc=1
//                and sticks at all-ones instead of wrapping.
//  Ports       : clk   in  clock, rising edge
//                rst   in  asynchronous active-high reset (clears count)
//                inc   in  count this cycle
//                count out current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter
  import fd_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fd_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fd_pipe_stage
//  Description : Fetch-to-Decode pipeline register with valid/ready handshake
//                and a one-entry skid slot behind the main register, giving
//                two entries of storage. in_ready is registered so Decode
//                stall never reaches Fetch combinationally. Flush discards
//                everything held and any beat accepted in the same cycle.
//  Ports       : clk  in  clock, rising edge
//                rst  in  asynchronous active-high reset
//                bus  fd_pipe_stage_if.slave (handshake, control, counters)
//  Revision    : 1.0  initial release
// ============================================================================
module fd_pipe_stage
  import fd_pkg::*;
#(
  parameter int                 INSTR_W      = DEF_INSTR_W,
  parameter int                 PC_W         = DEF_PC_W,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(DEF_BUBBLE_INSTR),
  parameter logic [PC_W-1:0]    BUBBLE_PC    = PC_W'(DEF_BUBBLE_PC),
  parameter int                 CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  fd_pipe_stage_if.slave   bus
);

  fd_state_t          state_q,      state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc4_q,   main_pc4_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc4_q,   skid_pc4_d;
  logic               in_ready_q,   in_ready_d;

  logic accept;
  logic consume;
  logic out_valid;

  assign out_valid = (state_q != S_EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign consume   = out_valid & ~bus.stall;

  // Next-state and datapath. Empty slots are always reloaded with bubble
  // values so Decode sees a NOP whenever out_valid is low.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc4_d   = main_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_instr_d = bus.in_instr;
          main_pc4_d   = bus.in_pc4;
          state_d      = S_FULL;
        end
      end
      S_FULL: begin
        if (accept && consume) begin
          main_instr_d = bus.in_instr;
          main_pc4_d   = bus.in_pc4;
        end else if (accept) begin
          skid_instr_d = bus.in_instr;
          skid_pc4_d   = bus.in_pc4;
          state_d      = S_SKID;
        end else if (consume) begin
          main_instr_d = BUBBLE_INSTR;
          main_pc4_d   = BUBBLE_PC;
          state_d      = S_EMPTY;
        end
      end
      S_SKID: begin
        // in_ready is low here, so no new beat can arrive alongside
        if (consume) begin
          main_instr_d = skid_instr_q;
          main_pc4_d   = skid_pc4_q;
          skid_instr_d = BUBBLE_INSTR;
          skid_pc4_d   = BUBBLE_PC;
          state_d      = S_FULL;
        end
      end
      default: begin
        main_instr_d = BUBBLE_INSTR;
        main_pc4_d   = BUBBLE_PC;
        skid_instr_d = BUBBLE_INSTR;
        skid_pc4_d   = BUBBLE_PC;
        state_d      = S_EMPTY;
      end
    endcase

    // Flush wins over stall and over any same-cycle accept (wrong path)
    if (bus.flush) begin
      main_instr_d = BUBBLE_INSTR;
      main_pc4_d   = BUBBLE_PC;
      skid_instr_d = BUBBLE_INSTR;
      skid_pc4_d   = BUBBLE_PC;
      state_d      = S_EMPTY;
    end

    in_ready_d = (state_d != S_SKID);
  end

  // in_ready resets low and rises on the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      main_instr_q <= BUBBLE_INSTR;
      main_pc4_q   <= BUBBLE_PC;
      skid_instr_q <= BUBBLE_INSTR;
      skid_pc4_q   <= BUBBLE_PC;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc4_q   <= main_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = main_instr_q;
  assign bus.out_pc4   = main_pc4_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & bus.stall),
    .count (bus.stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.flush),
    .count (bus.flush_cnt)
  );

endmodule : fd_pipe_stage
`default_nettype wire

// File: tb/tb_fd_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fd_pipe_stage
//  Description : Self-checking bench for fd_pipe_stage: a table of per-cycle
//                vectors with hand-computed outputs, then hand-written
//                sequences for counter saturation and async reset in SKID.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fd_pipe_stage;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] BUB_I   = 32'h0000_0000;
  localparam logic [31:0] BUB_PC  = 32'h0010_0000;
  localparam logic [31:0] PC_OFS  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fd_pipe_stage_if #(.INSTR_W(INSTR_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fd_pipe_stage #(
    .INSTR_W      (INSTR_W),
    .PC_W         (PC_W),
    .BUBBLE_INSTR (BUB_I),
    .BUBBLE_PC    (BUB_PC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic        st;
    logic        fl;
    logic        ov;
    logic [31:0] e_instr;
    logic        rdy;
    int          scnt;
    int          fcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s [%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] instr, input logic st,
                     input logic fl, input logic ov, input logic [31:0] e_instr,
                     input logic rdy, input int scnt, input int fcnt);
    vec_t v;
    v.iv = iv; v.instr = instr; v.st = st; v.fl = fl;
    v.ov = ov; v.e_instr = e_instr; v.rdy = rdy; v.scnt = scnt; v.fcnt = fcnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] instr,
                       input logic st, input logic fl);
    bus.in_valid = iv;
    bus.in_instr = instr;
    bus.in_pc4   = instr + PC_OFS;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic chk_out(input string nm, input int idx, input logic ov,
                         input logic [31:0] e_instr, input logic rdy);
    chk({nm, ".out_valid"}, idx, 32'(bus.out_valid), 32'(ov));
    chk({nm, ".out_instr"}, idx, bus.out_instr, ov ? e_instr : BUB_I);
    chk({nm, ".out_pc4"},   idx, bus.out_pc4, ov ? (e_instr + PC_OFS) : BUB_PC);
    chk({nm, ".in_ready"},  idx, 32'(bus.in_ready), 32'(rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // row: iv instr st fl | ov e_instr rdy stall_cnt flush_cnt
    // in_ready is still low on the first edge after release: 0x99 is refused
    add(1, 32'h99, 0, 0,  0, 32'h00, 1, 0, 0);
    // streaming, one-cycle latency
    add(1, 32'h11, 0, 0,  1, 32'h11, 1, 0, 0);
    add(1, 32'h22, 0, 0,  1, 32'h22, 1, 0, 0);
    add(1, 32'h33, 0, 0,  1, 32'h33, 1, 0, 0);
    add(0, 32'h00, 0, 0,  0, 32'h00, 1, 0, 0);
    // stall into skid; 0x33 offered but never accepted
    add(1, 32'h11, 0, 0,  1, 32'h11, 1, 0, 0);
    add(1, 32'h22, 1, 0,  1, 32'h11, 0, 1, 0);
    add(1, 32'h33, 1, 0,  1, 32'h11, 0, 2, 0);
    add(1, 32'h33, 1, 0,  1, 32'h11, 0, 3, 0);
    add(0, 32'h00, 0, 0,  1, 32'h22, 1, 3, 0);
    add(0, 32'h00, 0, 0,  0, 32'h00, 1, 3, 0);
    // flush while in SKID and stalled
    add(1, 32'hA1, 0, 0,  1, 32'hA1, 1, 3, 0);
    add(1, 32'hA2, 1, 0,  1, 32'hA1, 0, 4, 0);
    add(0, 32'h00, 1, 1,  0, 32'h00, 1, 5, 1);
    add(0, 32'h00, 0, 0,  0, 32'h00, 1, 5, 1);
    // flush with simultaneous accept: 0x44 dropped
    add(1, 32'h43, 0, 0,  1, 32'h43, 1, 5, 1);
    add(1, 32'h44, 0, 1,  0, 32'h00, 1, 5, 2);
    add(0, 32'h00, 0, 0,  0, 32'h00, 1, 5, 2);
    // FULL hold under stall without a new beat
    add(1, 32'h55, 0, 0,  1, 32'h55, 1, 5, 2);
    add(0, 32'h00, 1, 0,  1, 32'h55, 1, 6, 2);
    add(0, 32'h00, 0, 0,  0, 32'h00, 1, 6, 2);
    add(1, 32'h66, 0, 0,  1, 32'h66, 1, 6, 2);

    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 1'b0, BUB_I, 1'b0);
    chk("reset.stall_cnt", 0, 32'(bus.stall_cnt), 32'd0);
    chk("reset.flush_cnt", 0, 32'(bus.flush_cnt), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].instr, vecs[i].st, vecs[i].fl);
      @(posedge clk);
      #1;
      chk_out("vec", i, vecs[i].ov, vecs[i].e_instr, vecs[i].rdy);
      chk("vec.stall_cnt", i, 32'(bus.stall_cnt), 32'(vecs[i].scnt));
      chk("vec.flush_cnt", i, 32'(bus.flush_cnt), 32'(vecs[i].fcnt));
    end

    // stall counter saturates at 15 with CNT_W=4 (starts from 6 here)
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk_out("sat", k, 1'b1, 32'h66, 1'b1);
      chk("sat.stall_cnt", k, 32'(bus.stall_cnt), (6 + k > 15) ? 32'd15 : 32'(6 + k));
    end

    // enter SKID, then async reset between edges
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_out("skid77", 0, 1'b1, 32'h66, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("arst", 0, 1'b0, BUB_I, 1'b0);
    chk("arst.stall_cnt", 0, 32'(bus.stall_cnt), 32'd0);
    chk("arst.flush_cnt", 0, 32'(bus.flush_cnt), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("arst_hold", 0, 1'b0, BUB_I, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("arst_rel", 0, 1'b0, BUB_I, 1'b0);
    @(posedge clk);
    #1;
    chk_out("arst_edge", 0, 1'b0, BUB_I, 1'b1);

    // stage works again, neither 0x66 nor 0x77 resurfaces
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("post", 0, 1'b1, 32'h88, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("post", 1, 1'b0, BUB_I, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_fd_pipe_stage
`default_nettype wire

// File: doc/fd_pipe_stage.md
Name: fd_pipe_stage

Overview:
- Parametrised Fetch-to-Decode pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Upstream ready is registered, so downstream stall never propagates combinationally into Fetch.
- Flush (branch taken in Decode) overrides stall and injects a bubble. Flushes are no longer lost while stalled.
- Saturating stall and flush event counters support performance debug.

Parameters:
- INSTR_W, 32, instruction field width
- PC_W, 32, PC+4 field width
- BUBBLE_INSTR, 0, instruction value presented for a bubble/flushed slot
- BUBBLE_PC, 32'h00100000, PC+4 value presented for a bubble/flushed slot
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  Fetch presents a beat
- in_ready  out  1  stage can accept a beat (registered)
- in_instr  in  INSTR_W  fetched instruction
- in_pc4  in  PC_W  fetched PC+4
- stall  in  1  Decode cannot consume this cycle
- flush  in  1  discard all held and incoming beats (PCSrcD)
- out_valid  out  1  out_instr/out_pc4 hold a real beat
- out_instr  out  INSTR_W  Decode instruction
- out_pc4  out  PC_W  Decode PC+4
- stall_cnt  out  CNT_W  cycles with out_valid=1 and stall=1, saturating
- flush_cnt  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- Reset (asynchronous, held while rst=1): out_valid=0, skid empty, out_instr=BUBBLE_INSTR, out_pc4=BUBBLE_PC, in_ready=0, both counters 0. The first edge after release sets in_ready=1.
- Accept: accept = in_valid & in_ready. Consume: consume = out_valid & ~stall.
- States: EMPTY (main invalid), FULL (main valid, skid empty), SKID (main and skid valid). Registered in_ready = (state != SKID).
- EMPTY: accept loads main, goes to FULL, 1-cycle latency in->out. No accept: stays EMPTY.
- FULL: accept & consume loads main, stays FULL. Accept & ~consume loads skid, goes to SKID. ~accept & consume invalidates main and sets out_instr/out_pc4 to bubble values, goes to EMPTY. Neither: hold.
- SKID: in_ready=0, so no accept is possible. Consume moves skid to main and goes to FULL (in_ready=1 next cycle). ~consume: hold.
- Flush: highest priority, ignores stall and state. Next edge: state EMPTY, out_valid=0, out bubble values, skid cleared, in_ready=1. A beat accepted in the same cycle is dropped as wrong-path. in_ready seen by Fetch in the flush cycle is unchanged; the beat is still counted as accepted, then discarded.
- While out_valid=0, out_instr/out_pc4 always equal the bubble values, so Decode sees a NOP.
- Data is never reordered or duplicated. Each accepted, unflushed beat appears on the outputs exactly once with out_valid=1.
- Counters: +1 per qualifying cycle, saturate at all-ones (no wrap). Cleared only by rst.
- A reset mid-SKID discards both entries immediately.

Decomposition:
- Shared package fd_pkg: BUBBLE_INSTR/BUBBLE_PC defaults, state encoding constants (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2), default widths.
- One natural sub-module: sat_counter (CNT_W, inc, clk, rst → count), instantiated twice.

Test Plan:
- Reset then stream: rst pulse, in_valid=1 with in_instr=0x11,0x22,0x33 on consecutive cycles, stall=0 → out_valid rises the cycle after the first accept. Outputs 0x11,0x22,0x33 appear on consecutive cycles. in_ready stays 1.
- Stall into skid: main=0x11, stall=1 for 3 cycles while Fetch offers 0x22,0x33 → 0x22 is held in skid, in_ready=0, 0x33 is not accepted. After stall drops, outputs are 0x11 then 0x22, in_ready=1 again. stall_cnt=3.
- Flush while stalled: state SKID, stall=1, flush=1 for one cycle → next cycle out_valid=0, out_instr=0, out_pc4=0x00100000, in_ready=1. flush_cnt=1.
- Flush with simultaneous accept: FULL, in_valid=1, in_instr=0x44, flush=1 → 0x44 is never presented with out_valid=1.
- Counter saturation: CNT_W=4, stall=1 with out_valid=1 for 20 cycles → stall_cnt stops at 15.
- Async reset mid-operation: assert rst between clock edges in SKID → outputs go to reset values immediately without waiting for a clock edge. in_ready=0 until the first edge after release.
